fdiv_pack: RTL and testbench

Output stage of the single-precision floating-point divider: consumes the normalized quotient fraction and exponent-decrement bit from the mantissa divider, plus operand signs and exponents. It computes the result exponent, resolves special cases (NaN, ∞, zero, overflow, underflow), and packs an IEEE-754 word. It is a 2-stage valid/ready pipeline between the mantissa divider and the result writeback, sustaining full throughput.

---
 rtl/fdiv_pack.sv | 211 +++++++++++++++++++++
 tb/tb_fdiv_pack.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdiv_pack.sv
// ============================================================================
// fdiv_pack -- output stage of the single-precision floating-point divider.
//
// Takes the normalized quotient fraction and exponent-decrement bit from the
// mantissa divider together with the operand signs/exponents, works out the
// result exponent, resolves the special cases (NaN, Inf, zero, overflow,
// underflow) and packs an IEEE-754 word. Two-register valid/ready pipeline:
//   stage 1 : operand class decode, result sign, exponent, quotient fraction
//   stage 2 : packed out_data / out_flags
// Rounding is truncation; subnormal operands and results flush to zero.
//
// Configuration macro: FDIV_EXC_FLAGS_EN
//   defined   -> out_flags = {invalid, divzero, overflow, underflow}, registered
//   undefined -> flag logic absent, out_flags tied to 4'b0000
//
// Ports
//   clk, reset               rising-edge clock, synchronous active-high reset
//   in_valid / in_ready      upstream handshake
//   a_sign, b_sign           dividend / divisor sign
//   a_exp, b_exp             biased exponents
//   a_frac_zero, b_frac_zero operand fraction is all-zero
//   q_frac, q_dec            quotient fraction and exponent-decrement bit
//   out_valid / out_ready    downstream handshake
//   out_data                 {sign, exp, frac}
//   out_flags                {invalid, divzero, overflow, underflow}
// ============================================================================
module fdiv_pack #(
    parameter int WIDTH     = 23,
    parameter int EXP_WIDTH = 8,
    parameter int BIAS      = 127
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     a_sign,
    input  logic                     b_sign,
    input  logic [EXP_WIDTH-1:0]     a_exp,
    input  logic [EXP_WIDTH-1:0]     b_exp,
    input  logic                     a_frac_zero,
    input  logic                     b_frac_zero,
    input  logic [WIDTH-1:0]         q_frac,
    input  logic                     q_dec,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_WIDTH+WIDTH:0] out_data,
    output logic [3:0]               out_flags
);

    // Two guard bits keep a_exp - b_exp + BIAS - q_dec exact (no wrap).
    localparam int EW2 = EXP_WIDTH + 2;
    localparam int DW  = EXP_WIDTH + WIDTH + 1;

    localparam logic [EXP_WIDTH-1:0]  EXP_ONES  = {EXP_WIDTH{1'b1}};
    localparam logic [EXP_WIDTH-1:0]  EXP_ZERO  = {EXP_WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]      FRAC_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]      FRAC_QNAN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [EW2-1:0] BIAS_X    = EW2'(BIAS);
    localparam logic signed [EW2-1:0] EXP_OVF   = {2'b00, EXP_ONES};
    localparam logic signed [EW2-1:0] EXP_LOW   = {EW2{1'b0}};

    // ---------------- operand classification (feeds stage 1) ----------------
    logic a_max, b_max, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic cls_invalid;
    logic signed [EW2-1:0] exp_calc;

    assign a_max  = (a_exp == EXP_ONES);
    assign b_max  = (b_exp == EXP_ONES);
    assign a_nan  = a_max & ~a_frac_zero;
    assign b_nan  = b_max & ~b_frac_zero;
    assign a_inf  = a_max &  a_frac_zero;
    assign b_inf  = b_max &  b_frac_zero;
    // Subnormals are treated as zero regardless of their fraction.
    assign a_zero = (a_exp == EXP_ZERO);
    assign b_zero = (b_exp == EXP_ZERO);

    assign cls_invalid = a_nan | b_nan | (a_inf & b_inf) | (a_zero & b_zero);

    assign exp_calc = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp})
                    + BIAS_X - $signed({{(EW2-1){1'b0}}, q_dec});

    // ---------------- pipeline registers ----------------
    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_sign_q;
    logic                  s1_inv_q;
    logic                  s1_ainf_q;
    logic                  s1_bzero_q;
    logic                  s1_zero_q;
    logic signed [EW2-1:0] s1_exp_q;
    logic [WIDTH-1:0]      s1_frac_q;

    logic                  out_valid_q, out_valid_d;
    logic [DW-1:0]         out_data_q, out_data_d;

    logic s2_ready, s1_load, s2_load;

    // Handshake: each stage advances only when the stage after it can take data.
    always_comb begin
        s2_ready = ~out_valid_q | out_ready;
        in_ready = ~reset & (~s1_valid_q | s2_ready);
        s1_load  = in_valid & in_ready;
        s2_load  = s1_valid_q & s2_ready;
        if (s1_load) begin
            s1_valid_d = 1'b1;
        end else if (s2_ready) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (s2_ready) begin
            out_valid_d = s1_valid_q;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Result packing from stage-1 state; the if-chain order is the case priority.
    always_comb begin
        out_data_d = {DW{1'b0}};
        if (s1_inv_q) begin
            out_data_d = {1'b0, EXP_ONES, FRAC_QNAN};
        end else if (s1_ainf_q) begin
            out_data_d = {s1_sign_q, EXP_ONES, FRAC_ZERO};
        end else if (s1_bzero_q) begin
            // a is finite and nonzero here: both NaN and zero/zero are invalid.
            out_data_d = {s1_sign_q, EXP_ONES, FRAC_ZERO};
        end else if (s1_zero_q) begin
            out_data_d = {s1_sign_q, EXP_ZERO, FRAC_ZERO};
        end else if (s1_exp_q >= EXP_OVF) begin
            out_data_d = {s1_sign_q, EXP_ONES, FRAC_ZERO};
        end else if (s1_exp_q <= EXP_LOW) begin
            out_data_d = {s1_sign_q, EXP_ZERO, FRAC_ZERO};
        end else begin
            out_data_d = {s1_sign_q, s1_exp_q[EXP_WIDTH-1:0], s1_frac_q};
        end
    end

    // Stage-1 and stage-2 datapath/valid registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_inv_q    <= 1'b0;
            s1_ainf_q   <= 1'b0;
            s1_bzero_q  <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_exp_q    <= {EW2{1'b0}};
            s1_frac_q   <= FRAC_ZERO;
            out_valid_q <= 1'b0;
            out_data_q  <= {DW{1'b0}};
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            if (s1_load) begin
                s1_sign_q  <= a_sign ^ b_sign;
                s1_inv_q   <= cls_invalid;
                s1_ainf_q  <= a_inf;
                s1_bzero_q <= b_zero;
                s1_zero_q  <= a_zero | b_inf;
                s1_exp_q   <= exp_calc;
                s1_frac_q  <= q_frac;
            end
            if (s2_load) begin
                out_data_q <= out_data_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef FDIV_EXC_FLAGS_EN
    logic [3:0] out_flags_q, out_flags_d;

    // Exception flags follow the same priority as the packed result.
    always_comb begin
        out_flags_d = 4'b0000;
        if (s1_inv_q) begin
            out_flags_d = 4'b1000;
        end else if (s1_ainf_q) begin
            out_flags_d = 4'b0000;
        end else if (s1_bzero_q) begin
            out_flags_d = 4'b0100;
        end else if (s1_zero_q) begin
            out_flags_d = 4'b0000;
        end else if (s1_exp_q >= EXP_OVF) begin
            out_flags_d = 4'b0010;
        end else if (s1_exp_q <= EXP_LOW) begin
            out_flags_d = 4'b0001;
        end else begin
            out_flags_d = 4'b0000;
        end
    end

    // Flag register, loaded together with out_data.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_flags_q <= 4'b0000;
        end else if (s2_load) begin
            out_flags_q <= out_flags_d;
        end else begin
            out_flags_q <= out_flags_q;
        end
    end

    assign out_flags = out_flags_q;
`else
    assign out_flags = 4'b0000;
`endif

endmodule

// File: tb/tb_fdiv_pack.sv
module tb_fdiv_pack;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        a_sign, b_sign;
    logic [7:0]  a_exp, b_exp;
    logic        a_frac_zero, b_frac_zero;
    logic [22:0] q_frac;
    logic        q_dec;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_flags;

    always #5 clk = ~clk;

    fdiv_pack dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_sign(a_sign), .b_sign(b_sign),
        .a_exp(a_exp), .b_exp(b_exp),
        .a_frac_zero(a_frac_zero), .b_frac_zero(b_frac_zero),
        .q_frac(q_frac), .q_dec(q_dec),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_flags(out_flags)
    );

    typedef struct packed {
        logic        as, bs;
        logic [7:0]  ae, be;
        logic        afz, bfz;
        logic [22:0] qf;
        logic        qd;
    } op_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  flags;
    } res_t;

    res_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   rand_ready_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: IEEE-754 division output rules with plain integer arithmetic.
    function automatic res_t ref_model(input op_t o);
        res_t r;
        bit a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, s;
        int e;
        a_nan  = (o.ae == 8'd255) && !o.afz;
        b_nan  = (o.be == 8'd255) && !o.bfz;
        a_inf  = (o.ae == 8'd255) && o.afz;
        b_inf  = (o.be == 8'd255) && o.bfz;
        a_zero = (o.ae == 8'd0);
        b_zero = (o.be == 8'd0);
        s      = o.as ^ o.bs;
        e      = int'(o.ae) - int'(o.be) + 127 - int'(o.qd);
        if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
            r.data = 32'h7FC00000; r.flags = 4'b1000;
        end else if (a_inf) begin
            r.data = {s, 31'h7F800000}; r.flags = 4'b0000;
        end else if (b_zero) begin
            r.data = {s, 31'h7F800000}; r.flags = 4'b0100;
        end else if (a_zero || b_inf) begin
            r.data = {s, 31'h0}; r.flags = 4'b0000;
        end else if (e >= 255) begin
            r.data = {s, 31'h7F800000}; r.flags = 4'b0010;
        end else if (e <= 0) begin
            r.data = {s, 31'h0}; r.flags = 4'b0001;
        end else begin
            r.data = {s, e[7:0], o.qf}; r.flags = 4'b0000;
        end
`ifndef FDIV_EXC_FLAGS_EN
        r.flags = 4'b0000;
`endif
        return r;
    endfunction

    // Input monitor: every accepted transfer pushes its expected result.
    always @(negedge clk) begin
        if (reset) begin
            sb_q.delete();
        end else if (in_valid && in_ready) begin
            sb_q.push_back(ref_model({a_sign, b_sign, a_exp, b_exp, a_frac_zero,
                                      b_frac_zero, q_frac, q_dec}));
        end
    end

    // Output monitor: compares each delivered result and checks hold stability.
    bit          hold_pend = 1'b0;
    logic [31:0] hold_data;
    logic [3:0]  hold_flags;
    always @(negedge clk) begin
        res_t exp_r;
        if (reset) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", out_data, hold_data);
                check("hold_flags", 32'(out_flags), 32'(hold_flags));
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_output: got 0x%08h, expected no output", out_data);
                end else begin
                    exp_r = sb_q.pop_front();
                    check("out_data", out_data, exp_r.data);
                    check("out_flags", 32'(out_flags), 32'(exp_r.flags));
                end
            end
            hold_pend  = out_valid && !out_ready;
            hold_data  = out_data;
            hold_flags = out_flags;
        end
    end

    // Random downstream backpressure when enabled.
    always @(posedge clk) begin
        if (rand_ready_en) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic apply(input op_t o);
        {a_sign, b_sign, a_exp, b_exp, a_frac_zero, b_frac_zero, q_frac, q_dec} = o;
    endtask

    task automatic send(input op_t o);
        bit done = 1'b0;
        int cnt  = 0;
        apply(o);
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
            cnt++;
            if (!done && cnt > 1000) begin
                n_checks++; n_fail++;
                $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 1000 cycles");
                done = 1'b1;
            end
        end
    endtask

    task automatic drain();
        int cnt = 0;
        in_valid = 1'b0;
        while ((sb_q.size() != 0 || out_valid) && cnt < 300) begin
            @(posedge clk); #1; cnt++;
        end
        check("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    function automatic op_t mk(input logic as, bs, input logic [7:0] ae, be,
                               input logic afz, bfz, input logic [22:0] qf, input logic qd);
        return {as, bs, ae, be, afz, bfz, qf, qd};
    endfunction

    function automatic logic [7:0] rand_exp();
        case ($urandom_range(0, 5))
            0: return 8'd0;
            1: return 8'd255;
            2: return 8'd1;
            3: return 8'd254;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    op_t bp_ops[4];

    initial begin : main
        int idx;
        bit acc;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        apply(mk(1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 23'd0, 1'b0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_flags", 32'(out_flags), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // 6.0 / 2.0: empty after the accepting edge, result after the next one.
        send(mk(1'b0, 1'b0, 8'd129, 8'd128, 1'b0, 1'b1, 23'h400000, 1'b0));
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_not_yet", 32'(out_valid), 32'd0);
        @(posedge clk); @(negedge clk);
        check("lat_valid", 32'(out_valid), 32'd1);
        check("six_div_two", out_data, 32'h40400000);
        @(posedge clk); #1;

        // Directed cases: 1.0/1.5, specials, range limits, negative sign.
        send(mk(1'b0, 1'b0, 8'd127, 8'd127, 1'b1, 1'b0, 23'h2AAAAA, 1'b1));
        send(mk(1'b0, 1'b0, 8'd127, 8'd0,   1'b1, 1'b1, 23'h0, 1'b0));
        send(mk(1'b0, 1'b0, 8'd0,   8'd0,   1'b1, 1'b1, 23'h0, 1'b0));
        send(mk(1'b1, 1'b0, 8'd255, 8'd128, 1'b1, 1'b1, 23'h0, 1'b0));
        send(mk(1'b0, 1'b0, 8'd254, 8'd1,   1'b0, 1'b0, 23'h123456, 1'b0));
        send(mk(1'b0, 1'b0, 8'd1,   8'd200, 1'b0, 1'b0, 23'h654321, 1'b0));
        send(mk(1'b1, 1'b0, 8'd128, 8'd255, 1'b0, 1'b1, 23'h1, 1'b0));
        send(mk(1'b0, 1'b1, 8'd255, 8'd7,   1'b0, 1'b0, 23'h7, 1'b1));
        send(mk(1'b1, 1'b0, 8'd127, 8'd1,   1'b0, 1'b0, 23'h3, 1'b1));
        send(mk(1'b0, 1'b0, 8'd1,   8'd127, 1'b0, 1'b0, 23'h5, 1'b1));
        drain();

        // Backpressure: 4 items, out_ready low for 3 cycles.
        for (int i = 0; i < 4; i++)
            bp_ops[i] = mk(1'(i), 1'b0, 8'(120 + i), 8'd125, 1'b0, 1'b0, 23'(i * 4099 + 17), 1'(i));
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 3; c++) begin
            apply(bp_ops[idx]); in_valid = 1'b1;
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        @(negedge clk);
        check("bp_accepts", 32'(idx), 32'd2);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = idx; i < 4; i++) send(bp_ops[i]);
        drain();

        // Reset mid-stream: in-flight items are discarded.
        send(mk(1'b0, 1'b0, 8'd130, 8'd128, 1'b0, 1'b0, 23'h11, 1'b0));
        send(mk(1'b0, 1'b0, 8'd131, 8'd128, 1'b0, 1'b0, 23'h22, 1'b0));
        send(mk(1'b0, 1'b0, 8'd132, 8'd128, 1'b0, 1'b0, 23'h33, 1'b0));
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1 reset = 1'b0; in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("midrst_no_stale", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // Randomized traffic with random backpressure and idle cycles.
        rand_ready_en = 1'b1;
        for (int n = 0; n < 400; n++) begin
            send(mk(1'($urandom), 1'($urandom), rand_exp(), rand_exp(),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    23'($urandom), 1'($urandom)));
            if ($urandom_range(0, 4) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        rand_ready_en = 1'b0;
        @(posedge clk); #2 out_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
